// File: rtl/glb_ld_dma.sv
// glb_ld_dma: load DMA for one GLB tile. Queues load headers, issues 64-bit bank reads, unpacks into a 16-bit stream.
// Header replay (repeat_on) is only compiled in when GLB_LD_DMA_REPEAT_EN is defined.
package global_buffer_pkg;
    localparam int PKG_ADDR_WIDTH      = 22;
    localparam int PKG_NUM_WORDS_WIDTH = 21;

    typedef struct packed {
        logic                           valid;
        logic                           repeat_on;
        logic                           inactive_on;
        logic [PKG_ADDR_WIDTH-1:0]      start_addr;
        logic [PKG_NUM_WORDS_WIDTH-1:0] num_words;
        logic [PKG_NUM_WORDS_WIDTH-1:0] num_active_words;
        logic [PKG_NUM_WORDS_WIDTH-1:0] num_inactive_words;
    } dma_ld_header_t;
endpackage

module glb_ld_dma
    import global_buffer_pkg::dma_ld_header_t;
#(
    parameter int GLB_ADDR_WIDTH      = 22,
    parameter int MAX_NUM_WORDS_WIDTH = 21,
    parameter int BANK_DATA_WIDTH     = 64,
    parameter int CGRA_DATA_WIDTH     = 16,
    parameter int QUEUE_DEPTH         = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       hdr_wr_en,
    input  dma_ld_header_t             hdr_wr_data,
    output logic                       hdr_full,
    input  logic                       strm_start_pulse,
    output logic                       rdrq_en,
    output logic [GLB_ADDR_WIDTH-1:0]  rdrq_addr,
    input  logic                       rdrs_data_valid,
    input  logic [BANK_DATA_WIDTH-1:0] rdrs_data,
    output logic [CGRA_DATA_WIDTH-1:0] stream_data_out,
    output logic                       stream_data_valid,
    output logic                       busy,
    output logic                       done_pulse
);
    localparam int LANES = BANK_DATA_WIDTH / CGRA_DATA_WIDTH;
    localparam int LW    = $clog2(LANES);
    localparam int PW    = $clog2(QUEUE_DEPTH);
    localparam int CW    = $clog2(QUEUE_DEPTH + 1);
    localparam int NW    = MAX_NUM_WORDS_WIDTH;

    // state  | meaning
    // S_IDLE | waiting for a start with a queued header
    // S_REQ  | one-cycle read request for the current address
    // S_WAIT | waiting for the in-order read response
    // S_EMIT | one lane per cycle onto the stream
    // S_GAP  | inactive cycles between bursts of active words
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_EMIT, S_GAP} state_t;

    state_t                     state_q, state_d;
    dma_ld_header_t             fifo_q [QUEUE_DEPTH];
    logic [PW-1:0]              wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]              count_q;
    logic                       fifo_empty, fifo_full, push, pop;
    dma_ld_header_t             head, hdr_q, next_hdr;
    logic [GLB_ADDR_WIDTH-1:0]  addr_q;
    logic [BANK_DATA_WIDTH-1:0] data_q;
    logic [NW-1:0]              total_cnt_q, active_cnt_q, gap_cnt_q;
    logic [LW-1:0]              lane_q;
    logic                       lanes_spent_q, done_q;
    logic                       load, restart, finish, gap_hit, last_word, repeat_req;
    logic                       unused_hdr_bits;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(QUEUE_DEPTH));
    assign push       = hdr_wr_en && !fifo_full;
    assign head       = fifo_q[rd_ptr_q];
    assign hdr_full   = fifo_full;
    assign next_hdr   = load ? head : hdr_q;

`ifdef GLB_LD_DMA_REPEAT_EN
    assign repeat_req = hdr_q.repeat_on;
    assign unused_hdr_bits = hdr_q.valid;
`else
    assign repeat_req = 1'b0;
    assign unused_hdr_bits = ^{hdr_q.valid, hdr_q.repeat_on};
`endif

    assign last_word = ((total_cnt_q + NW'(1)) == hdr_q.num_words);
    // A zero-length inactive phase never enters GAP; the burst simply continues.
    assign gap_hit   = hdr_q.inactive_on && (hdr_q.num_active_words != '0) &&
                       (hdr_q.num_inactive_words != '0) &&
                       ((active_cnt_q + NW'(1)) == hdr_q.num_active_words);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= hdr_wr_data;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d           = state_q;
        pop               = 1'b0;
        load              = 1'b0;
        restart           = 1'b0;
        finish            = 1'b0;
        rdrq_en           = 1'b0;
        stream_data_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (strm_start_pulse && !fifo_empty) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    state_d = (head.num_words == '0) ? S_IDLE : S_REQ;
                end
            end
            S_REQ: begin
                rdrq_en = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (rdrs_data_valid) state_d = S_EMIT;
            end
            S_EMIT: begin
                stream_data_valid = 1'b1;
                if (last_word) begin
                    if (repeat_req && fifo_empty) begin
                        restart = 1'b1;
                        state_d = S_REQ;
                    end else if (repeat_req) begin
                        pop     = 1'b1;
                        load    = 1'b1;
                        finish  = 1'b1;
                        state_d = (head.num_words == '0) ? S_IDLE : S_REQ;
                    end else begin
                        finish  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (gap_hit) begin
                    state_d = S_GAP;
                end else if (lane_q == LW'(LANES - 1)) begin
                    // Next read overlaps the last lane of this one.
                    rdrq_en = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_GAP: begin
                if (gap_cnt_q <= NW'(1)) state_d = lanes_spent_q ? S_REQ : S_EMIT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_q         <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            total_cnt_q   <= '0;
            active_cnt_q  <= '0;
            gap_cnt_q     <= '0;
            lane_q        <= '0;
            lanes_spent_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= finish || (load && (head.num_words == '0));
            if (load || restart) begin
                hdr_q         <= next_hdr;
                addr_q        <= {next_hdr.start_addr[GLB_ADDR_WIDTH-1:3], 3'b000};
                total_cnt_q   <= '0;
                active_cnt_q  <= '0;
                lane_q        <= '0;
                lanes_spent_q <= 1'b0;
            end else begin
                if (rdrq_en) begin
                    addr_q        <= addr_q + GLB_ADDR_WIDTH'(8);
                    lanes_spent_q <= 1'b0;
                end
                if (state_q == S_WAIT && rdrs_data_valid) data_q <= rdrs_data;
                if (stream_data_valid) begin
                    total_cnt_q <= total_cnt_q + NW'(1);
                    lane_q      <= lane_q + LW'(1);
                    if (gap_hit) begin
                        active_cnt_q  <= '0;
                        gap_cnt_q     <= hdr_q.num_inactive_words;
                        lanes_spent_q <= (lane_q == LW'(LANES - 1));
                    end else begin
                        active_cnt_q <= active_cnt_q + NW'(1);
                    end
                end
                if (state_q == S_GAP) gap_cnt_q <= gap_cnt_q - NW'(1);
            end
        end
    end

    assign rdrq_addr       = rdrq_en ? addr_q : '0;
    assign stream_data_out = stream_data_valid ?
                             data_q[int'(lane_q)*CGRA_DATA_WIDTH +: CGRA_DATA_WIDTH] : '0;
    assign busy            = (state_q != S_IDLE);
    assign done_pulse      = done_q;
endmodule
